// File: rtl/mbx_ombx_rd_ctrl.sv
// rtl/mbx_ombx_rd_ctrl.sv - outbound mailbox read sequencer: SRAM window walk into a one-word RDATA stage.
// Optional limit check on the read pointer: define MBX_RD_RANGE_CHECK_EN.
module mbx_ombx_rd_ctrl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned SizeWidth = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mbx_read_i,
  input  logic                 mbx_clear_i,
  input  logic [AddrWidth-1:0] sram_base_addr_i,
  input  logic [AddrWidth-1:0] sram_limit_addr_i,
  input  logic [SizeWidth-1:0] obj_size_dw_i,
  output logic                 sram_req_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  input  logic                 sram_gnt_i,
  input  logic                 sram_rvalid_i,
  input  logic [31:0]          sram_rdata_i,
  input  logic                 sram_rerror_i,
  output logic [31:0]          sys_rdata_o,
  output logic                 sys_rdata_valid_o,
  input  logic                 sys_pop_i,
  output logic                 sys_read_all_o,
  output logic                 rd_error_o,
  output logic [AddrWidth-1:0] rd_ptr_o
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWaitRsp, StHold, StDone, StDrain
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic [SizeWidth-1:0] rem_q, rem_d;
  logic [31:0]          hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic                 read_all_q, read_all_d;
  logic                 err_q, err_d;
  logic                 abort;
  logic                 range_fail_base;
  logic                 range_fail_ptr;

`ifdef MBX_RD_RANGE_CHECK_EN
  assign range_fail_base = sram_base_addr_i > sram_limit_addr_i;
  assign range_fail_ptr  = ptr_q > sram_limit_addr_i;
`else
  logic unused_limit;
  assign unused_limit    = ^sram_limit_addr_i;
  assign range_fail_base = 1'b0;
  assign range_fail_ptr  = 1'b0;
`endif

  // Read dropping in the middle of an object behaves exactly like a clear.
  assign abort = mbx_clear_i ||
                 (!mbx_read_i && (state_q inside {StFetch, StWaitRsp, StHold}));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    read_all_d = 1'b0;
    err_d      = 1'b0;
    sram_req_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (!mbx_clear_i && mbx_read_i) begin
          if (obj_size_dw_i == '0) begin
            read_all_d = 1'b1;
            state_d    = StDone;
          end else if (range_fail_base) begin
            err_d = 1'b1;
          end else begin
            ptr_d   = sram_base_addr_i;
            rem_d   = obj_size_dw_i;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          sram_req_o = 1'b1;
          if (sram_gnt_i) begin
            ptr_d   = ptr_q + AddrWidth'(4);
            state_d = StWaitRsp;
          end
        end
      end
      StWaitRsp: begin
        // A response landing together with the abort needs no draining.
        if (abort) begin
          state_d = sram_rvalid_i ? StIdle : StDrain;
        end else if (sram_rvalid_i) begin
          if (sram_rerror_i) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            hold_d  = sram_rdata_i;
            valid_d = 1'b1;
            rem_d   = (rem_q == '0) ? '0 : rem_q - SizeWidth'(1);
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (sys_pop_i && valid_q) begin
          valid_d = 1'b0;
          if (rem_q == '0) begin
            read_all_d = 1'b1;
            state_d    = StDone;
          end else if (range_fail_ptr) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (mbx_clear_i || !mbx_read_i) state_d = StIdle;
      end
      StDrain: begin
        if (sram_rvalid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (mbx_clear_i) begin
      valid_d    = 1'b0;
      read_all_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rem_q      <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      read_all_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      read_all_q <= read_all_d;
      err_q      <= err_d;
    end
  end

  assign sram_addr_o       = sram_req_o ? ptr_q : '0;
  assign sys_rdata_o       = valid_q ? hold_q : 32'h0;
  assign sys_rdata_valid_o = valid_q;
  assign sys_read_all_o    = read_all_q;
  assign rd_error_o        = err_q;
  assign rd_ptr_o          = ptr_q;

endmodule
